// File: rtl/riscv_bp_pkg.sv
// Shared branch-prediction types: opcode constants, the IF->EX prediction record
// and the predictor update payload. The fetch-side BTB imports the same package.
package riscv_bp_pkg;

  localparam int BP_XLEN = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [BP_XLEN-1:0] pc;
    logic               taken;
    logic [BP_XLEN-1:0] target;
  } pred_rec_t;

  typedef struct packed {
    logic [BP_XLEN-1:0] pc;
    logic [BP_XLEN-1:0] target;
    logic               taken;
  } bp_upd_t;

  function automatic logic is_cf(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch push, EX resolve, redirect and predictor-update signals of the branch resolve unit.
// The slave modport is the unit itself; master is the surrounding pipeline/predictor.
interface branch_resolve_unit_if
  import riscv_bp_pkg::*;
#(
  parameter int XLEN  = BP_XLEN,
  parameter int CNT_W = 16
);

  logic            pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [31:0]     ex_inst;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;

  logic            flush;
  logic [XLEN-1:0] redirect_pc;

  logic            upd_valid;
  logic            upd_ready;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;

  logic            q_full;
  logic            q_empty;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  ex_valid, ex_pc, ex_inst, ex_taken, ex_target,
    input  upd_ready,
    output flush, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken,
    output q_full, q_empty, br_count, mis_count
  );

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output ex_valid, ex_pc, ex_inst, ex_taken, ex_target,
    output upd_ready,
    input  flush, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    input  q_full, q_empty, br_count, mis_count
  );

endinterface

// File: rtl/pred_fifo.sv
// In-flight prediction queue between IF and EX: push/pop/clear with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pred_fifo
  import riscv_bp_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pred_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  input  logic clear,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  T mem_q [DEPTH];

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           do_push;
  logic           do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // A pop frees a slot in the same cycle, so push+pop is legal when full.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && !clear && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-side branch resolution: pops the fetch prediction, detects mispredicts,
// pulses flush with the redirect PC and queues a one-entry predictor update.
module branch_resolve_unit
  import riscv_bp_pkg::*;
#(
  parameter int XLEN  = BP_XLEN,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);

  pred_rec_t push_rec;
  pred_rec_t head;
  pred_rec_t pred;
  logic      q_full;
  logic      q_empty;
  logic      pop;
  logic      head_hit;
  logic      cf;
  logic      mispredict;
  logic      upd_new;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;

  logic            flush_q, flush_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            upd_valid_q, upd_valid_d;
  bp_upd_t         upd_q, upd_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mis_count_q, mis_count_d;

  assign push_rec = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};
  assign pop      = bus.ex_valid;

  pred_fifo #(
    .DEPTH (DEPTH),
    .T     (pred_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.pred_valid),
    .push_data (push_rec),
    .pop       (pop),
    .clear     (mispredict),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    cf       = is_cf(bus.ex_inst[6:0]);
    pc_plus4 = bus.ex_pc + XLEN'(4);
    head_hit = !q_empty && (head.pc == bus.ex_pc);
    // A missing or stale record means fetch predicted plain fall-through.
    pred = head;
    if (!head_hit) begin
      pred.pc     = bus.ex_pc;
      pred.taken  = 1'b0;
      pred.target = pc_plus4;
    end
    next_pc    = (cf && bus.ex_taken) ? bus.ex_target : pc_plus4;
    mispredict = bus.ex_valid &&
                 ((cf && ((pred.taken != bus.ex_taken) ||
                          (bus.ex_taken && (pred.target != bus.ex_target)))) ||
                  (!cf && pred.taken));
    upd_new    = bus.ex_valid && cf && (mispredict || !head_hit);
  end

  always_comb begin
    flush_d       = mispredict;
    redirect_pc_d = mispredict ? next_pc : redirect_pc_q;

    upd_valid_d = upd_valid_q;
    upd_d       = upd_q;
    // A fresh update overrides both the held one and a same-cycle accept.
    if (upd_new) begin
      upd_valid_d = 1'b1;
      upd_d       = '{pc: bus.ex_pc, target: bus.ex_target, taken: bus.ex_taken};
    end else if (upd_valid_q && bus.upd_ready) begin
      upd_valid_d = 1'b0;
    end

    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;
    if (bus.ex_valid && cf && (br_count_q != '1))
      br_count_d = br_count_q + CNT_W'(1);
    if (mispredict && (mis_count_q != '1))
      mis_count_d = mis_count_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_q         <= '0;
      br_count_q    <= '0;
      mis_count_q   <= '0;
    end else begin
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      upd_valid_q   <= upd_valid_d;
      upd_q         <= upd_d;
      br_count_q    <= br_count_d;
      mis_count_q   <= mis_count_d;
    end
  end

  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_pc      = upd_q.pc;
  assign bus.upd_target  = upd_q.target;
  assign bus.upd_taken   = upd_q.taken;
  assign bus.q_full      = q_full;
  assign bus.q_empty     = q_empty;
  assign bus.br_count    = br_count_q;
  assign bus.mis_count   = mis_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: stimulus pushes expected flushes/updates
// into scoreboard queues; a negedge monitor pops and compares whenever the DUT emits one.
module tb_branch_resolve_unit;
  import riscv_bp_pkg::*;

  localparam logic [31:0] I_BRANCH = 32'h0000_0063;
  localparam logic [31:0] I_JALR   = 32'h0000_8067;
  localparam logic [31:0] I_ADDI   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bus ();

  branch_resolve_unit #(.XLEN(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_br  = 0;
  int exp_mis = 0;

  logic [31:0] exp_flush_q [$];
  bp_upd_t     exp_upd_q   [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every flush pulse and every update handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (bus.flush === 1'b1) begin
      if (exp_flush_q.size() == 0) begin
        check("unexpected_flush", 64'(bus.redirect_pc), 64'hDEAD);
      end else begin
        check("redirect_pc", 64'(bus.redirect_pc), 64'(exp_flush_q.pop_front()));
      end
    end
    if (bus.upd_valid === 1'b1 && bus.upd_ready === 1'b1) begin
      if (exp_upd_q.size() == 0) begin
        check("unexpected_update", 64'(bus.upd_pc), 64'hDEAD);
      end else begin
        bp_upd_t e;
        e = exp_upd_q.pop_front();
        check("upd_pc",     64'(bus.upd_pc),     64'(e.pc));
        check("upd_target", 64'(bus.upd_target), 64'(e.target));
        check("upd_taken",  64'(bus.upd_taken),  64'(e.taken));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_rec(input logic [31:0] pc, input logic taken, input logic [31:0] target);
    bus.pred_valid  = 1'b1;
    bus.pred_pc     = pc;
    bus.pred_taken  = taken;
    bus.pred_target = target;
    step();
    bus.pred_valid  = 1'b0;
  endtask

  // Drives one EX resolution and records what the DUT must produce for it.
  task automatic resolve(input logic [31:0] pc, input logic [31:0] inst, input logic taken,
                         input logic [31:0] target, input logic exp_flush,
                         input logic [31:0] exp_redirect, input logic exp_upd);
    bus.ex_valid  = 1'b1;
    bus.ex_pc     = pc;
    bus.ex_inst   = inst;
    bus.ex_taken  = taken;
    bus.ex_target = target;
    if (exp_flush) exp_flush_q.push_back(exp_redirect);
    if (exp_upd)   exp_upd_q.push_back('{pc: pc, target: target, taken: taken});
    if (is_cf(inst[6:0]) && exp_br < 16'hFFFF) exp_br++;
    if (exp_flush && exp_mis < 16'hFFFF) exp_mis++;
    step();
    bus.ex_valid  = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_br_count"},  64'(bus.br_count),  64'(exp_br));
    check({tag, "_mis_count"}, 64'(bus.mis_count), 64'(exp_mis));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q_empty"},     64'(bus.q_empty),     64'd1);
    check({tag, "_q_full"},      64'(bus.q_full),      64'd0);
    check({tag, "_flush"},       64'(bus.flush),       64'd0);
    check({tag, "_redirect_pc"}, 64'(bus.redirect_pc), 64'd0);
    check({tag, "_upd_valid"},   64'(bus.upd_valid),   64'd0);
    check({tag, "_upd_pc"},      64'(bus.upd_pc),      64'd0);
    check({tag, "_upd_target"},  64'(bus.upd_target),  64'd0);
    check({tag, "_upd_taken"},   64'(bus.upd_taken),   64'd0);
    check({tag, "_br_count"},    64'(bus.br_count),    64'd0);
    check({tag, "_mis_count"},   64'(bus.mis_count),   64'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.pred_valid  = 1'b0;
    bus.pred_pc     = '0;
    bus.pred_taken  = 1'b0;
    bus.pred_target = '0;
    bus.ex_valid    = 1'b0;
    bus.ex_pc       = '0;
    bus.ex_inst     = '0;
    bus.ex_taken    = 1'b0;
    bus.ex_target   = '0;
    bus.upd_ready   = 1'b1;
    idle(2);
    check_reset_state("reset");
    rst = 1'b0;
    idle(1);

    // Correct prediction: no flush, no update, one branch counted.
    push_rec(32'h100, 1'b1, 32'h140);
    resolve(32'h100, I_BRANCH, 1'b1, 32'h140, 1'b0, 32'h0, 1'b0);
    check("correct_q_empty", 64'(bus.q_empty), 64'd1);
    check("correct_flush",   64'(bus.flush),   64'd0);
    check_counters("correct");
    idle(2);

    // Direction mispredict clears the younger record.
    push_rec(32'h200, 1'b0, 32'h0);
    push_rec(32'h204, 1'b0, 32'h0);
    resolve(32'h200, I_BRANCH, 1'b1, 32'h180, 1'b1, 32'h180, 1'b1);
    check("dir_flush",   64'(bus.flush),   64'd1);
    check("dir_q_empty", 64'(bus.q_empty), 64'd1);
    idle(1);
    check("dir_flush_pulse", 64'(bus.flush), 64'd0);
    check_counters("dir");
    idle(2);

    // Update backpressure: the second update overwrites the held first one.
    bus.upd_ready = 1'b0;
    push_rec(32'h300, 1'b0, 32'h0);
    resolve(32'h300, I_BRANCH, 1'b1, 32'h320, 1'b1, 32'h320, 1'b0);
    resolve(32'h340, I_BRANCH, 1'b1, 32'h380, 1'b1, 32'h380, 1'b1);
    check("bp_upd_valid",  64'(bus.upd_valid),  64'd1);
    check("bp_upd_pc",     64'(bus.upd_pc),     64'h340);
    idle(2);
    check("bp_upd_pc_hold",     64'(bus.upd_pc),     64'h340);
    check("bp_upd_target_hold", 64'(bus.upd_target), 64'h380);
    bus.upd_ready = 1'b1;
    idle(1);
    check("bp_upd_done", 64'(bus.upd_valid), 64'd0);
    check_counters("bp");
    idle(1);

    // Full queue: fifth push dropped, then push+pop keeps occupancy.
    for (int i = 0; i < 4; i++) push_rec(32'h600 + 32'(4 * i), 1'b0, 32'h0);
    check("full_q_full",  64'(bus.q_full),  64'd1);
    check("full_q_empty", 64'(bus.q_empty), 64'd0);
    push_rec(32'h610, 1'b0, 32'h0);
    check("full_drop_q_full", 64'(bus.q_full), 64'd1);
    bus.pred_valid  = 1'b1;
    bus.pred_pc     = 32'h610;
    bus.pred_taken  = 1'b0;
    bus.pred_target = 32'h0;
    resolve(32'h600, I_ADDI, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    bus.pred_valid  = 1'b0;
    check("pushpop_q_full", 64'(bus.q_full), 64'd1);
    // Draining in order with matching branches must not raise updates or flushes.
    for (int i = 1; i <= 4; i++)
      resolve(32'h600 + 32'(4 * i), I_BRANCH, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("drain_q_empty", 64'(bus.q_empty), 64'd1);
    check_counters("drain");
    idle(1);

    // Non-cf instruction hitting a taken record, then JALR wrap at the top of memory.
    push_rec(32'h400, 1'b1, 32'h500);
    resolve(32'h400, I_ADDI, 1'b0, 32'h0, 1'b1, 32'h404, 1'b0);
    idle(1);
    push_rec(32'hFFFF_FFFC, 1'b1, 32'h40);
    resolve(32'hFFFF_FFFC, I_JALR, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    check("wrap_redirect", 64'(bus.redirect_pc), 64'h0);
    idle(1);
    check_counters("wrap");
    idle(1);

    // Reset while an update is held and a new mispredict is resolving.
    bus.upd_ready = 1'b0;
    push_rec(32'h500, 1'b0, 32'h0);
    resolve(32'h500, I_BRANCH, 1'b1, 32'h600, 1'b1, 32'h600, 1'b0);
    check("pre_rst_upd_valid", 64'(bus.upd_valid), 64'd1);
    #5;
    rst           = 1'b1;
    bus.ex_valid  = 1'b1;
    bus.ex_pc     = 32'h504;
    bus.ex_inst   = I_BRANCH;
    bus.ex_taken  = 1'b1;
    bus.ex_target = 32'h900;
    step();
    bus.ex_valid  = 1'b0;
    check_reset_state("midrst");
    rst = 1'b0;
    bus.upd_ready = 1'b1;
    exp_br  = 0;
    exp_mis = 0;
    idle(3);
    check("post_rst_flush", 64'(bus.flush), 64'd0);
    check_counters("post_rst");

    check("pending_flushes", 64'(exp_flush_q.size()), 64'd0);
    check("pending_updates", 64'(exp_upd_q.size()),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
